// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, with sign pre/post fix-up.
// Build option MULDIV_FAST_MUL_EN: multiplies finish in PREP through a combinational multiplier.

module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic                is_div_s;
  logic                sgn_a_s, sgn_b_s;
  logic [XLEN-1:0]     mag_a_s, mag_b_s;
  logic [XLEN:0]       mul_add_s;
  logic [2*XLEN-1:0]   mul_next_s;
  logic [XLEN:0]       div_shl_s;
  logic [XLEN+1:0]     div_diff_s;
  logic [2*XLEN-1:0]   div_next_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, fix_res_s;

  // Operand sign extraction and magnitudes; op[2] marks divide, op[1] remainder, op[0] unsigned divide
  always_comb begin
    is_div_s = op_q[2];
    sgn_a_s  = ((op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM))
               && a_q[XLEN-1];
    sgn_b_s  = ((op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM)) && b_q[XLEN-1];
    mag_a_s  = sgn_a_s ? (-a_q) : a_q;
    mag_b_s  = sgn_b_s ? (-b_q) : b_q;
  end

  // One iteration of each algorithm; acc holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_add_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    if (acc_q[0]) begin
      mul_next_s = {mul_add_s, acc_q[XLEN-1:1]};
    end else begin
      mul_next_s = {1'b0, acc_q[2*XLEN-1:1]};
    end
    div_shl_s  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff_s = {1'b0, div_shl_s} - {2'b00, b_q};
    if (div_diff_s[XLEN+1]) begin
      div_next_s = {div_shl_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Sign correction and result selection for the FIX state
  always_comb begin
    prod_s = neg_q ? (-acc_q) : acc_q;
    quo_s  = neg_q ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_s  = neg_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        fix_res_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res_s = quo_s;
      OP_REM, OP_REMU:               fix_res_s = rem_s;
      default:                       fix_res_s = ZERO;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a_s, fast_b_s, fast_prod_s;

  // Sign-extended operands; the low 2*XLEN bits of their product equal the exact signed product
  always_comb begin
    fast_a_s    = {{XLEN{sgn_a_s}}, a_q};
    fast_b_s    = {{XLEN{sgn_b_s}}, b_q};
    fast_prod_s = fast_a_s * fast_b_s;
  end
`endif

  // Next-state and datapath update; flush overrides everything except reset
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            op_d    = op;
            a_d     = rs1;
            b_d     = rs2;
            state_d = S_PREP;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PREP: begin
          acc_d = {ZERO, mag_a_s};
          b_d   = mag_b_s;
          cnt_d = {CW{1'b0}};
          if (is_div_s && op_q[1]) begin
            neg_d = sgn_a_s;
          end else begin
            neg_d = sgn_a_s ^ sgn_b_s;
          end
          if (is_div_s && (b_q == ZERO)) begin
            result_d = op_q[1] ? a_q : ONES;
            state_d  = S_DONE;
          end else if (is_div_s && !op_q[0] && (a_q == SMIN) && (b_q == ONES)) begin
            result_d = op_q[1] ? ZERO : SMIN;
            state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div_s) begin
            result_d = (op_q == OP_MUL) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
            state_d  = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          acc_d = is_div_s ? div_next_s : mul_next_s;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = {CW{1'b0}};
            state_d = S_FIX;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = S_CALC;
          end
        end
        S_FIX: begin
          result_d = fix_res_s;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b000;
      a_q         <= ZERO;
      b_q         <= ZERO;
      acc_q       <= {2*XLEN{1'b0}};
      cnt_q       <= {CW{1'b0}};
      neg_q       <= 1'b0;
      result_q    <= ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M vectors, special cases, backpressure,
// aborts and randomized operations against an arithmetic reference model.

module tb_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks;
  int errors;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [31:0] SMIN = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (f)
      3'b000: begin p = sa * sb; ref_model = p[31:0]; end
      3'b001: begin p = sa * sb; ref_model = p[63:32]; end
      3'b010: begin p = sa * ub; ref_model = p[63:32]; end
      3'b011: begin p = ua * ub; ref_model = p[63:32]; end
      3'b100: begin
        if (b == 32'd0) ref_model = ONES;
        else if (a == SMIN && b == ONES) ref_model = SMIN;
        else begin p = sa / sb; ref_model = p[31:0]; end
      end
      3'b101: begin
        if (b == 32'd0) ref_model = ONES;
        else begin p = ua / ub; ref_model = p[31:0]; end
      end
      3'b110: begin
        if (b == 32'd0) ref_model = a;
        else if (a == SMIN && b == ONES) ref_model = 32'd0;
        else begin p = sa % sb; ref_model = p[31:0]; end
      end
      3'b111: begin
        if (b == 32'd0) ref_model = a;
        else begin p = ua % ub; ref_model = p[31:0]; end
      end
      default: ref_model = 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && ((b == 32'd0) || (!f[0] && a == SMIN && b == ONES))) exp_lat = 1;
    else if (!f[2] && FAST) exp_lat = 1;
    else exp_lat = 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = ONES;
      2: v = SMIN;
      3: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op (caller sits just after a posedge) and wait for out_valid; lat=-1 on timeout
  task automatic exec_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
    op = f; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
    res = result;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
  endtask

  task automatic test_directed();
    logic [2:0]  fv [12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                             3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] av [12] = '{32'd7, SMIN, ONES, ONES, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, SMIN, SMIN};
    logic [31:0] bv [12] = '{32'hFFFF_FFFD, SMIN, ONES, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'd0, ONES, ONES};
    logic [31:0] ev [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, ONES, 32'hFFFF_FFFD, ONES,
                             32'd14, 32'd2, ONES, 32'd5, SMIN, 32'd0};
    int          lv [12];
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 12; i++) lv[i] = (i < 4) ? (FAST ? 1 : 34) : ((i < 8) ? 34 : 1);
    for (int i = 0; i < 12; i++) begin
      exec_op(fv[i], av[i], bv[i], res, lat);
      checks++;
      if (res !== ev[i]) begin
        errors++; $display("FAIL directed_result[%0d] op=%0d got %h want %h", i, fv[i], res, ev[i]);
      end
      checks++;
      if (lat != lv[i]) begin
        errors++; $display("FAIL directed_latency[%0d] op=%0d got %0d want %0d", i, fv[i], lat, lv[i]);
      end
      ack();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int          lat;
    int          bad;
    exec_op(3'b101, 32'd100, 32'd7, res, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL backpressure_hold got %0d unstable cycles want 0 (ov=%b res=%h)", bad, out_valid, result);
    end
    ack();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    op = 3'b000; rs1 = 32'd3; rs2 = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL backpressure_reissue got busy=%b in_ready=%b want 1/0", busy, in_ready);
    end
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd15) begin
      errors++; $display("FAIL backpressure_reissue_result got %h want %h", result, 32'd15);
    end
    ack();
  endtask

  // Abort a divide in CALC iteration 10 with flush (use_rst=0) or rst (use_rst=1)
  task automatic test_abort(input bit use_rst);
    logic [31:0] res;
    int          lat;
    int          seen;
    exec_op(3'b101, 32'd100, 32'd7, res, lat);
    ack();
    op = 3'b100; rs1 = 32'h1234_5678; rs2 = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy rst=%0d got %b want 1", use_rst, busy); end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle rst=%0d got busy=%b in_ready=%b out_valid=%b want 0/1/0",
                         use_rst, busy, in_ready, out_valid);
    end
    checks++;
    if (result !== (use_rst ? 32'd0 : 32'd14)) begin
      errors++; $display("FAIL abort_result rst=%0d got %h want %h", use_rst, result, use_rst ? 32'd0 : 32'd14);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_valid rst=%0d got %0d valid cycles want 0", use_rst, seen); end
  endtask

  task automatic test_flush_idle();
    op = 3'b000; rs1 = 32'd2; rs2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle_discard got busy=%b in_ready=%b want 0/1", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic [31:0] exp2;
    int          lat;
    exec_op(3'b110, 32'hFFFF_FF9C, 32'd7, res, lat);
    checks++;
    if (res !== ref_model(3'b110, 32'hFFFF_FF9C, 32'd7)) begin
      errors++; $display("FAIL b2b_first got %h want %h", res, ref_model(3'b110, 32'hFFFF_FF9C, 32'd7));
    end
    op = 3'b001; rs1 = 32'h7FFF_0001; rs2 = 32'hFFFF_8000; in_valid = 1'b1; out_ready = 1'b1;
    exp2 = ref_model(3'b001, 32'h7FFF_0001, 32'hFFFF_8000);
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_no_same_cycle got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_valid !== 1'b1 || result !== exp2 || lat != exp_lat(3'b001, 32'h7FFF_0001, 32'hFFFF_8000)) begin
      errors++; $display("FAIL b2b_second got %h lat %0d want %h lat %0d", result, lat, exp2,
                         exp_lat(3'b001, 32'h7FFF_0001, 32'hFFFF_8000));
    end
    ack();
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, res, exp;
    int          lat;
    for (int n = 0; n < 60; n++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp = ref_model(f, a, b);
      exec_op(f, a, b, res, lat);
      checks++;
      if (res !== exp || lat != exp_lat(f, a, b)) begin
        errors++; $display("FAIL random[%0d] op=%0d a=%h b=%h got %h lat %0d want %h lat %0d",
                           n, f, a, b, res, lat, exp, exp_lat(f, a, b));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ack();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'b000; rs1 = 32'd0; rs2 = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_idle();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
